// File: rtl/modq_pkg.sv
// Shared constants and FSM state encoding for the mod-Q product generator.
package modq_pkg;

  localparam int MODQ_Q = 3329;
  localparam int MODQ_N = 25;
  localparam int MODQ_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    SEND = 2'b10
  } state_t;

endpackage

// File: rtl/modq_shift_add_step.sv
// One shift-add multiply step: conditionally add the shifted multiplicand, then shift it left.
module modq_shift_add_step #(
  parameter int W = 12
) (
  input  logic [2*W-1:0] acc,
  input  logic [2*W-1:0] mcand,
  input  logic           mplier_lsb,
  output logic [2*W-1:0] acc_next,
  output logic [2*W-1:0] mcand_next
);

  assign acc_next   = mplier_lsb ? (acc + mcand) : acc;
  assign mcand_next = {mcand[2*W-2:0], 1'b0};

endmodule

// File: rtl/modq_prod_gen.sv
// Sequential W-cycle shift-add multiplier feeding a mod-Q reducer over a start/ack handshake.
// Optional MODQ_NEG_EN adds neg_in, which makes prod_out the two's-complement negation of the product.
module modq_prod_gen
  import modq_pkg::*;
#(
  parameter int n = MODQ_N,
  parameter int W = MODQ_W,
  parameter int Q = MODQ_Q
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         in_valid,
`ifdef MODQ_NEG_EN
  input  logic         neg_in,
`endif
  output logic         in_ready,
  output logic [n-1:0] prod_out,
  output logic         start,
  input  logic         ack,
  output logic [1:0]   dbg_state
);

  // Handshakes: an operand pair is taken on an edge where in_valid && in_ready;
  // start holds with a stable prod_out until an edge samples ack, then drops.

  if (2 * W > n) begin : g_width_chk
    $error("modq_prod_gen: product word n narrower than 2*W");
  end
  if (Q >= (1 << W)) begin : g_q_chk
    $error("modq_prod_gen: modulus Q does not fit in W bits");
  end

  state_t         state;
  state_t         next_state;
  logic [3:0]     cnt;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] acc_next;
  logic [2*W-1:0] mcand_next;
  logic [n-1:0]   prod_ext;
  logic [n-1:0]   result;
  logic           last_step;

  modq_shift_add_step #(.W(W)) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier_lsb (mplier[0]),
    .acc_next   (acc_next),
    .mcand_next (mcand_next)
  );

  assign last_step = (cnt == 4'(W - 1));
  assign prod_ext  = n'(acc_next);

`ifdef MODQ_NEG_EN
  logic neg_reg;
  assign result = neg_reg ? (~prod_ext + n'(1)) : prod_ext;
`else
  assign result = prod_ext;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = MUL;
      end
      MUL: begin
        if (last_step) next_state = SEND;
      end
      SEND: begin
        if (ack) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign dbg_state = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      prod_out <= '0;
      start    <= 1'b0;
`ifdef MODQ_NEG_EN
      neg_reg  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc     <= '0;
            mcand   <= {{W{1'b0}}, a_in};
            mplier  <= b_in;
            cnt     <= '0;
`ifdef MODQ_NEG_EN
            neg_reg <= neg_in;
`endif
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand_next;
          mplier <= {1'b0, mplier[W-1:1]};
          cnt    <= cnt + 4'd1;
          if (last_step) begin
            prod_out <= result;
            start    <= 1'b1;
          end
        end
        SEND: begin
          if (ack) start <= 1'b0;
        end
        default: start <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_modq_prod_gen.sv
// Directed self-checking bench for modq_prod_gen (build with MODQ_NEG_EN to cover negation).
`timescale 1ns/1ps
module tb_modq_prod_gen;

  localparam int N = 25;
  localparam int W = 12;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         in_valid = 1'b0;
  logic         neg_in = 1'b0;
  logic         in_ready;
  logic [N-1:0] prod_out;
  logic         start;
  logic         ack = 1'b0;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  modq_prod_gen #(.n(N), .W(W), .Q(3329)) dut (
    .clock     (clock),
    .reset     (reset),
    .a_in      (a_in),
    .b_in      (b_in),
    .in_valid  (in_valid),
`ifdef MODQ_NEG_EN
    .neg_in    (neg_in),
`endif
    .in_ready  (in_ready),
    .prod_out  (prod_out),
    .start     (start),
    .ack       (ack),
    .dbg_state (dbg_state)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic neg);
    @(negedge clock);
    a_in = a; b_in = b; neg_in = neg; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; neg_in = 1'b0;
  endtask

  task automatic wait_start(input int budget, output int edges);
    edges = 0;
    while (!start && edges < budget) begin
      @(posedge clock); #1;
      edges++;
    end
  endtask

  task automatic do_ack();
    @(negedge clock);
    ack = 1'b1;
    @(posedge clock); #1;
    ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b want 0", start); end
    n_checks++; if (prod_out !== 25'h0) begin n_fail++; $display("FAIL reset_prod got %h want 0", prod_out); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready); end
    n_checks++; if (dbg_state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b want 00", dbg_state); end
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_product(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic neg, input logic [N-1:0] exp);
    int edges;
    accept(a, b, neg);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s_busy got %b want 0", name, in_ready); end
    wait_start(20, edges);
    n_checks++; if (edges !== 12) begin n_fail++; $display("FAIL %s_latency got %0d want 12", name, edges); end
    n_checks++; if (prod_out !== exp) begin n_fail++; $display("FAIL %s_prod got %h want %h", name, prod_out, exp); end
    do_ack();
  endtask

  task automatic test_products();
    test_product("max",  12'd3328, 12'd3328, 1'b0, 25'h0A90000);
    test_product("zero", 12'd0,    12'd123,  1'b0, 25'h0);
    test_product("ovq",  12'd3329, 12'd2,    1'b0, 25'd6658);
    test_product("full", 12'd4095, 12'd4095, 1'b0, 25'd16769025);
`ifdef MODQ_NEG_EN
    test_product("neg1", 12'd1,    12'd1,    1'b1, 25'h1FFFFFF);
    test_product("neg7", 12'd7,    12'd9,    1'b1, 25'h1FFFFC1);
`else
    test_product("one",  12'd1,    12'd1,    1'b1, 25'h0000001);
    n_checks++; if (prod_out[N-1] !== 1'b0) begin n_fail++; $display("FAIL nonneg_msb got %b want 0", prod_out[N-1]); end
`endif
  endtask

  task automatic test_hold_ack();
    int edges;
    logic [N-1:0] held;
    accept(12'd100, 12'd33, 1'b0);
    wait_start(20, edges);
    held = 25'd3300;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      n_checks++; if (start !== 1'b1 || prod_out !== held) begin
        n_fail++; $display("FAIL hold_%0d got start=%b prod=%h want 1 %h", i, start, prod_out, held);
      end
    end
    do_ack();
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL hold_release_start got %b want 0", start); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_ready got %b want 1", in_ready); end
  endtask

  task automatic test_ignore();
    int edges;
    accept(12'd5, 12'd7, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    a_in = 12'd1; b_in = 12'd1; in_valid = 1'b1; ack = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; ack = 1'b0;
    wait_start(20, edges);
    n_checks++; if (edges !== 8) begin n_fail++; $display("FAIL ignore_latency got %0d want 8", edges); end
    n_checks++; if (prod_out !== 25'd35) begin n_fail++; $display("FAIL ignore_prod got %h want %h", prod_out, 25'd35); end
    @(negedge clock);
    a_in = 12'd2; b_in = 12'd2; in_valid = 1'b1;
    @(posedge clock); #1;
    n_checks++; if (dbg_state !== 2'b10 || start !== 1'b1) begin
      n_fail++; $display("FAIL ignore_send got state=%b start=%b want 10 1", dbg_state, start);
    end
    @(negedge clock);
    ack = 1'b1;
    @(posedge clock); #1;
    ack = 1'b0; in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || dbg_state !== 2'b00) begin
      n_fail++; $display("FAIL ignore_same_edge got ready=%b state=%b want 1 00", in_ready, dbg_state);
    end
    @(posedge clock); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ignore_no_accept got %b want 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    int edges;
    accept(12'd100, 12'd200, 1'b0);
    repeat (6) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (start !== 1'b0 || prod_out !== 25'h0) begin
      n_fail++; $display("FAIL midreset_outputs got start=%b prod=%h want 0 0", start, prod_out);
    end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready got %b want 1", in_ready); end
    @(negedge clock); reset = 1'b0;
    wait_start(20, edges);
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL midreset_no_pulse got %b want 0", start); end
    test_product("after_reset", 12'd3328, 12'd2, 1'b0, 25'd6656);
  endtask

  task automatic test_back_to_back();
    int edges;
    int t1;
    int t2;
    accept(12'd10, 12'd20, 1'b0);
    wait_start(20, edges);
    t1 = cyc;
    n_checks++; if (prod_out !== 25'd200) begin n_fail++; $display("FAIL b2b_first got %h want %h", prod_out, 25'd200); end
    do_ack();
    accept(12'd3000, 12'd3001, 1'b0);
    wait_start(20, edges);
    t2 = cyc;
    n_checks++; if (prod_out !== 25'd9003000) begin n_fail++; $display("FAIL b2b_second got %h want %h", prod_out, 25'd9003000); end
    n_checks++; if (t2 - t1 !== 14) begin n_fail++; $display("FAIL b2b_spacing got %0d want 14", t2 - t1); end
    do_ack();
  endtask

  initial begin
    test_reset();
    test_products();
    test_hold_ack();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
